// File: rtl/com_pkg.sv
// Shared definitions for the com link: FSM states, slot timing and frame-slot indices.
package com_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEAD   = 2'd1,
    SYNC   = 2'd2,
    STREAM = 2'd3
  } tx_state_e;

  localparam int SLOT_CYCLES = 4;
  localparam int LEAD_CYCLES = 4;

  localparam int FRAME_SLOTS_NOPAR = 10;
  localparam int FRAME_SLOTS_PAR   = 11;

  localparam logic [3:0] FS_LAST_NOPAR = 4'd9;
  localparam logic [3:0] FS_LAST_PAR   = 4'd10;
  localparam logic [3:0] FS_IDLE       = 4'hF;

endpackage

// File: rtl/com_tx_if.sv
// Byte handshake between the byte source (master) and com_tx (slave).
// A byte moves on every rising clk edge where tx_valid & tx_ready; tx_ready never depends on tx_valid.
interface com_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/com_tx_slot_gen.sv
// Slot-cycle counter: wraps 0..SLOT_CYCLES-1 while streaming, held at 0 otherwise.
module com_tx_slot_gen
  import com_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_slot_last
);

  logic [1:0] r_sc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc <= 2'd0;
    end else if (!i_run) begin
      r_sc <= 2'd0;
    end else begin
      r_sc <= r_sc + 2'd1;
    end
  end

  assign o_slot_last = (r_sc == 2'(SLOT_CYCLES - 1));

endmodule

// File: rtl/com_tx.sv
// com link transmitter: lead/sync bring-up, then framed 4x oversampled byte stream on pin_txd.
// Optional even-parity slot before the stop bit when COM_TX_PARITY_EN is defined.
module com_tx
  import com_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      fire,
  com_tx_if.slave   tx,
  output logic      pin_txd,
  output logic      busy,
  output tx_state_e dbg_state
);

`ifdef COM_TX_PARITY_EN
  localparam logic [3:0] FS_LAST = FS_LAST_PAR;
`else
  localparam logic [3:0] FS_LAST = FS_LAST_NOPAR;
`endif
  localparam logic [1:0] LEAD_LAST = 2'(LEAD_CYCLES - 1);

  tx_state_e  r_state;
  logic [1:0] r_lead_cnt;
  logic [3:0] r_fs;
  logic [7:0] r_shift;
  logic       r_pin;
  logic       r_busy;

  logic       w_slot_last;
  logic       w_ready;
  logic       w_accept;
  logic       w_slot_bit;
  logic [2:0] w_bit_idx;

  com_tx_slot_gen u_slot_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (r_state == STREAM),
    .o_slot_last (w_slot_last)
  );

  // A new byte is taken only on the last cycle of an idle-fill or final frame slot.
  assign w_ready  = (r_state == STREAM) && w_slot_last &&
                    ((r_fs == FS_IDLE) || (r_fs == FS_LAST));
  assign w_accept = w_ready && tx.tx_valid;
  assign tx.tx_ready = w_ready;

  // Bit of the slot indexed by r_fs; it reaches the pin one clock later through r_pin.
  always_comb begin
    w_slot_bit = 1'b0;
    w_bit_idx  = 3'(4'd8 - r_fs);
    if (r_fs == 4'd0) begin
      w_slot_bit = 1'b1;
    end else if (r_fs <= 4'd8) begin
      w_slot_bit = r_shift[w_bit_idx];
`ifdef COM_TX_PARITY_EN
    end else if (r_fs == 4'd9) begin
      w_slot_bit = ^r_shift;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lead_cnt <= 2'd0;
      r_fs       <= FS_IDLE;
      r_shift    <= 8'd0;
      r_pin      <= 1'b0;
      r_busy     <= 1'b0;
    end else if (!fire) begin
      r_state    <= IDLE;
      r_lead_cnt <= 2'd0;
      r_fs       <= FS_IDLE;
      r_pin      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= LEAD;
          r_lead_cnt <= 2'd0;
          r_pin      <= 1'b0;
          r_busy     <= 1'b0;
        end
        LEAD: begin
          r_pin <= 1'b0;
          if (r_lead_cnt == LEAD_LAST) begin
            r_state <= SYNC;
          end else begin
            r_lead_cnt <= r_lead_cnt + 2'd1;
          end
        end
        SYNC: begin
          r_pin   <= 1'b1;
          r_fs    <= FS_IDLE;
          r_state <= STREAM;
        end
        STREAM: begin
          r_pin  <= w_slot_bit;
          r_busy <= (r_fs != FS_IDLE);
          if (w_slot_last) begin
            if (w_accept) begin
              r_fs    <= 4'd0;
              r_shift <= tx.tx_data;
            end else if (r_fs == FS_LAST) begin
              r_fs <= FS_IDLE;
            end else if (r_fs != FS_IDLE) begin
              r_fs <= r_fs + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pin_txd   = r_pin;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_com_tx.sv
// Directed bench for com_tx: pin/busy/ready logs per clock edge, byte scoreboard and a model receiver.
module tb_com_tx;
  import com_pkg::*;

`ifdef COM_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FCYC  = NSLOT * 4;
  localparam int LOG_N = 4096;

  logic      clk;
  logic      rst_n;
  logic      fire;
  logic      pin_txd;
  logic      busy;
  tx_state_e dbg_state;

  com_tx_if tx_if ();

  com_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fire      (fire),
    .tx        (tx_if.slave),
    .pin_txd   (pin_txd),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic pin_log  [0:LOG_N-1];
  logic busy_log [0:LOG_N-1];
  logic rdy_log  [0:LOG_N-1];

  logic [7:0] exp_q[$];
  logic [7:0] feed_q[$];
  int         acc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note any handshake, advance, log outputs after the edge.
  task automatic tick();
    logic acc;
    acc = tx_if.tx_valid & tx_if.tx_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < LOG_N) begin
      pin_log[cyc]  = pin_txd;
      busy_log[cyc] = busy;
      rdy_log[cyc]  = tx_if.tx_ready;
    end
    if (acc) begin
      exp_q.push_back(tx_if.tx_data);
      acc_q.push_back(cyc);
      if (feed_q.size() > 0) begin
        tx_if.tx_data = feed_q.pop_front();
      end else begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_accepts(input int n, input string tag);
    int k;
    k = 0;
    while (acc_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 64'(acc_q.size() >= n), 64'd1);
  endtask

  function automatic logic slot_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b1;
    if (s <= 8) return b[8 - s];
    if (NSLOT == 11 && s == 9) return ^b;
    return 1'b0;
  endfunction

  task automatic check_bringup(input string tag, input int f);
    logic [3:0]  lead;
    logic        fill;
    logic        bsy;
    run_until(f + 12);
    for (int i = 0; i < 4; i++) lead[i] = pin_log[f + 1 + i];
    fill = 1'b0;
    for (int i = f + 6; i <= f + 12; i++) fill = fill | pin_log[i];
    bsy = 1'b0;
    for (int i = f + 1; i <= f + 12; i++) bsy = bsy | busy_log[i];
    chk({tag, "_lead"}, 64'(lead), 64'd0);
    chk({tag, "_sync"}, 64'(pin_log[f + 5]), 64'd1);
    chk({tag, "_fill"}, 64'(fill), 64'd0);
    chk({tag, "_busy"}, 64'(bsy), 64'd0);
  endtask

  // Pops one accepted byte, checks the whole frame on the pin and recovers it by majority vote.
  task automatic check_frame(input string tag);
    int          t;
    logic [7:0]  b;
    logic [7:0]  rx;
    logic [43:0] obs_p;
    logic [43:0] exp_p;
    logic [43:0] obs_b;
    logic        s0, s1, s2;
    if (acc_q.size() == 0 || exp_q.size() == 0) return;
    t = acc_q.pop_front();
    b = exp_q.pop_front();
    run_until(t + FCYC + 1);
    obs_p = '0;
    exp_p = '0;
    obs_b = '0;
    for (int s = 0; s < NSLOT; s++) begin
      for (int j = 0; j < 4; j++) begin
        obs_p[s*4 + j] = pin_log[t + 1 + s*4 + j];
        exp_p[s*4 + j] = slot_bit(b, s);
        obs_b[s*4 + j] = busy_log[t + 1 + s*4 + j];
      end
    end
    rx = '0;
    for (int s = 1; s <= 8; s++) begin
      s0 = pin_log[t + 1 + s*4];
      s1 = pin_log[t + 2 + s*4];
      s2 = pin_log[t + 3 + s*4];
      rx[8 - s] = (s0 & s1) | (s0 & s2) | (s1 & s2);
    end
    chk({tag, "_pin"},  64'(obs_p), 64'(exp_p));
    chk({tag, "_busy"}, 64'(obs_b), (64'd1 << FCYC) - 64'd1);
    chk({tag, "_rx"},   64'(rx),    64'(b));
  endtask

  initial begin
    int   t;
    int   f;
    logic quiet;

    rst_n          = 1'b0;
    fire           = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    tick();
    tick();
    chk("reset_pin",   64'(pin_txd),        64'd0);
    chk("reset_ready", 64'(tx_if.tx_ready), 64'd0);
    chk("reset_busy",  64'(busy),           64'd0);
    chk("reset_state", 64'(dbg_state),      64'(IDLE));

    rst_n = 1'b1;
    quiet = 1'b0;
    repeat (20) begin
      tick();
      quiet = quiet | pin_txd | tx_if.tx_ready | busy | (dbg_state != IDLE);
    end
    chk("idle_quiet", 64'(quiet), 64'd0);

    // bring-up
    fire = 1'b1;
    f = cyc + 1;
    check_bringup("bringup", f);
    chk("state_stream", 64'(dbg_state), 64'(STREAM));

    // single byte
    tx_if.tx_data  = 8'hA5;
    tx_if.tx_valid = 1'b1;
    wait_accepts(1, "single_accept");
    if (acc_q.size() > 0) begin
      t = acc_q[0];
      check_frame("single");
      chk("single_busy_edges", 64'({busy_log[t], busy_log[t + FCYC + 1]}), 64'd0);
      chk("single_ready_next", 64'({rdy_log[t + FCYC - 2], rdy_log[t + FCYC - 1]}), 64'b01);
    end

    // back-to-back
    feed_q.push_back(8'hFF);
    feed_q.push_back(8'h3C);
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b1;
    wait_accepts(3, "b2b_accept");
    if (acc_q.size() >= 3) begin
      chk("b2b_gap1", 64'(acc_q[1] - acc_q[0]), 64'(FCYC));
      chk("b2b_gap2", 64'(acc_q[2] - acc_q[1]), 64'(FCYC));
    end
    check_frame("b2b0");
    check_frame("b2b1");
    check_frame("b2b2");

    // abort mid-frame
    tx_if.tx_data  = 8'hFF;
    tx_if.tx_valid = 1'b1;
    wait_accepts(1, "abort_accept");
    if (acc_q.size() > 0 && exp_q.size() > 0) begin
      t = acc_q.pop_front();
      void'(exp_q.pop_front());
      run_until(t + 20);
      fire = 1'b0;
      tick();
      chk("abort_pre_pin",  64'(pin_log[t + 20]),  64'd1);
      chk("abort_pin",      64'(pin_log[t + 21]),  64'd0);
      chk("abort_busy",     64'(busy_log[t + 21]), 64'd0);
      chk("abort_state",    64'(dbg_state),        64'(IDLE));
    end
    fire = 1'b0;
    repeat (3) tick();
    fire = 1'b1;
    f = cyc + 1;
    check_bringup("rebringup", f);
    tx_if.tx_data  = 8'h5A;
    tx_if.tx_valid = 1'b1;
    wait_accepts(1, "reaccept");
    check_frame("after_abort");

    // asynchronous reset mid-frame
    tx_if.tx_data  = 8'hE7;
    tx_if.tx_valid = 1'b1;
    wait_accepts(1, "areset_accept");
    if (acc_q.size() > 0 && exp_q.size() > 0) begin
      t = acc_q.pop_front();
      void'(exp_q.pop_front());
      run_until(t + 13);
      chk("areset_pre_pin",  64'(pin_txd), 64'd1);
      chk("areset_pre_busy", 64'(busy),    64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_pin",   64'(pin_txd),        64'd0);
      chk("areset_busy",  64'(busy),           64'd0);
      chk("areset_ready", 64'(tx_if.tx_ready), 64'd0);
      chk("areset_state", 64'(dbg_state),      64'(IDLE));
    end
    tick();
    rst_n = 1'b1;
    chk("release_state", 64'(dbg_state), 64'(IDLE));
    f = cyc + 1;
    check_bringup("post_reset", f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
